// File: rtl/seq_nibble_comp_ctrl_if.sv
// Start/done handshake and operand/result bus for the nibble-serial compare sequencer.
// The master drives the request; the slave (the sequencer) returns status and result.
interface seq_nibble_comp_ctrl_if #(
   parameter int NIBBLES = 4
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES + 1);

   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic          gt;
   logic          eq;
   logic          lt;
   logic [CW-1:0] ncmp;

   modport master (
      output start, a, b,
      input  busy, done, gt, eq, lt, ncmp
   );

   modport slave (
      input  start, a, b,
      output busy, done, gt, eq, lt, ncmp
   );
endinterface

// File: rtl/seq_nibble_comp_ctrl.sv
// Compares two wide unsigned operands one nibble per cycle, MSB nibble first,
// stopping at the first differing nibble; one shared 4-bit slice plus control.
module seq_nibble_comp_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   seq_nibble_comp_ctrl_if.slave   bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES + 1);
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic {IDLE, COMP} state_t;

   state_t        state;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_shift;
   logic [W-1:0]  b_shift;
   logic [3:0]    a_nib;
   logic [3:0]    b_nib;

   // The single shared slice: select nibble[idx] of each captured operand.
   always_comb begin
      a_shift = a_reg >> {idx, 2'b00};
      b_shift = b_reg >> {idx, 2'b00};
      a_nib   = a_shift[3:0];
      b_nib   = b_shift[3:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         idx      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.gt   <= 1'b0;
         bus.eq   <= 1'b0;
         bus.lt   <= 1'b0;
         bus.ncmp <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_reg    <= bus.a;
                  b_reg    <= bus.b;
                  idx      <= IW'(NIBBLES - 1);
                  bus.busy <= 1'b1;
                  bus.gt   <= 1'b0;
                  bus.eq   <= 1'b0;
                  bus.lt   <= 1'b0;
                  bus.ncmp <= '0;
                  state    <= COMP;
               end
            end
            COMP: begin
               bus.ncmp <= bus.ncmp + CW'(1);
               if (a_nib > b_nib) begin
                  bus.gt   <= 1'b1;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else if (a_nib < b_nib) begin
                  bus.lt   <= 1'b1;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else if (idx == '0) begin
                  bus.eq   <= 1'b1;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_nibble_comp_ctrl.sv
// Self-checking bench for seq_nibble_comp_ctrl: directed table, corner sequences,
// and randomized compares against a prefix-compare reference model.
module tb_seq_nibble_comp_ctrl;
   localparam int NIB = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   seq_nibble_comp_ctrl_if #(.NIBBLES(NIB)) bus ();
   seq_nibble_comp_ctrl_if #(.NIBBLES(1))   bus1 ();

   seq_nibble_comp_ctrl #(.NIBBLES(NIB)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   seq_nibble_comp_ctrl #(.NIBBLES(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        gt;
      logic        eq;
      logic        lt;
      int          ncmp;
      string       name;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference: the first nibble (from MSB) where the operand prefixes diverge.
   task automatic model(input logic [15:0] av, input logic [15:0] bv,
                        output logic g, output logic e, output logic l, output int n);
      bit found;
      g = (av > bv);
      l = (av < bv);
      e = (av == bv);
      n = NIB;
      found = 0;
      for (int m = 1; m <= NIB; m++) begin
         if (!found && ((av >> (4 * (NIB - m))) != (bv >> (4 * (NIB - m))))) begin
            n = m;
            found = 1;
         end
      end
   endtask

   task automatic run_cmp(input logic [15:0] av, input logic [15:0] bv,
                          input logic eg, input logic ee, input logic el,
                          input int en, input string nm);
      int cnt;
      bit got;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
      check({nm, " busy after accept"}, 32'(bus.busy), 32'd1);
      check({nm, " flags cleared"}, {bus.gt, bus.eq, bus.lt, 29'(bus.ncmp)}, 32'd0);
      cnt = 0;
      got = 0;
      while (cnt < 20 && !got) begin
         @(negedge clk);
         cnt++;
         got = bus.done;
      end
      check({nm, " latency"}, 32'(cnt), 32'(en));
      check({nm, " gt/eq/lt"}, {29'd0, bus.gt, bus.eq, bus.lt}, {29'd0, eg, ee, el});
      check({nm, " ncmp"}, 32'(bus.ncmp), 32'(en));
      check({nm, " busy at done"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      check({nm, " done pulse width"}, 32'(bus.done), 32'd0);
      check({nm, " result held"}, {bus.gt, bus.eq, bus.lt, 29'(bus.ncmp)},
            {eg, ee, el, 29'(en)});
   endtask

   vec_t vecs[6];

   initial begin
      logic [15:0] ra, rb;
      logic g, e, l;
      int   n, k;
      bit   seen;

      n_checks = 0;
      n_pass   = 0;
      vecs[0] = '{16'h9000, 16'h8FFF, 1, 0, 0, 1, "msb_gt"};
      vecs[1] = '{16'h12F0, 16'h1300, 0, 0, 1, 2, "second_lt"};
      vecs[2] = '{16'hABCD, 16'hABCD, 0, 1, 0, 4, "equal"};
      vecs[3] = '{16'h1234, 16'h1235, 0, 0, 1, 4, "lsb_lt"};
      vecs[4] = '{16'hFFFF, 16'h0000, 1, 0, 0, 1, "max_vs_zero"};
      vecs[5] = '{16'h5A70, 16'h5A6F, 1, 0, 0, 3, "third_gt"};

      rst_n = 1'b0;
      bus.start = 0;  bus.a = '0;  bus.b = '0;
      bus1.start = 0; bus1.a = '0; bus1.b = '0;
      #12;
      check("reset outputs", {bus.busy, bus.done, bus.gt, bus.eq, bus.lt, 27'(bus.ncmp)}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Abort in the middle of a compare: outputs clear at once, no done follows.
      @(negedge clk);
      bus.start = 1; bus.a = 16'h1234; bus.b = 16'h1235;
      @(negedge clk);
      bus.start = 0;
      @(negedge clk);
      check("abort busy before reset", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort outputs cleared", {bus.busy, bus.done, bus.gt, bus.eq, bus.lt, 27'(bus.ncmp)}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen = 1;
      end
      check("abort no done", 32'(seen), 32'd0);

      foreach (vecs[i])
         run_cmp(vecs[i].a, vecs[i].b, vecs[i].gt, vecs[i].eq, vecs[i].lt, vecs[i].ncmp, vecs[i].name);

      // Start held high; operands changed while busy; re-accept in the done cycle.
      @(negedge clk);
      bus.start = 1; bus.a = 16'h5000; bus.b = 16'h5001;
      @(negedge clk);
      bus.a = 16'hFFFF; bus.b = 16'h0000;
      n = 0;
      while (n < 20 && !bus.done) begin
         @(negedge clk);
         n++;
      end
      check("held start latency", 32'(n), 32'd4);
      check("held start uses captured", {29'd0, bus.gt, bus.eq, bus.lt}, 32'b001);
      check("held start ncmp", 32'(bus.ncmp), 32'd4);
      @(negedge clk);
      check("b2b re-accept busy", 32'(bus.busy), 32'd1);
      check("b2b flags cleared", {bus.done, bus.gt, bus.eq, bus.lt, 28'(bus.ncmp)}, 32'd0);
      bus.start = 0;
      @(negedge clk);
      check("b2b second result", {bus.done, bus.gt, bus.eq, bus.lt, 28'(bus.ncmp)},
            {1'b1, 1'b1, 1'b0, 1'b0, 28'd1});

      // Randomized compares with shared high prefixes to exercise every depth.
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = ra;
         k  = $urandom_range(0, 4);
         for (int j = 0; j < k; j++) rb[4*j +: 4] = 4'($urandom);
         model(ra, rb, g, e, l, n);
         run_cmp(ra, rb, g, e, l, n, $sformatf("rand%0d", i));
      end

      // Single-nibble instance: every compare takes one cycle with ncmp=1.
      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom_range(0, 15));
         rb = (i % 3 == 0) ? ra : 16'($urandom_range(0, 15));
         @(negedge clk);
         bus1.start = 1; bus1.a = ra[3:0]; bus1.b = rb[3:0];
         @(negedge clk);
         bus1.start = 0;
         check("n1 busy", 32'(bus1.busy), 32'd1);
         @(negedge clk);
         check($sformatf("n1 result %0d", i), {bus1.done, bus1.gt, bus1.eq, bus1.lt, 28'(bus1.ncmp)},
               {1'b1, ra > rb, ra == rb, ra < rb, 28'd1});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
